// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_DRIVE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_EMIT
  } scan_state_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned code_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Per-bit multi-flop synchroniser for asynchronous inputs; reset value is configurable.
module sync_2ff
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned STAGES    = SYNC_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= {WIDTH{RESET_VAL}};
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanned key matrix with shared settle timer, scan-level debounce and event handshake.
// Define KEYPAD_SCANNER_RELEASE_EVENTS_EN to report key releases as events.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_SCANS = 8,
  parameter logic        IDLE_LEVEL     = 1'b1,
  localparam int unsigned CW            = code_width(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      row_out,
  input  logic [COLS-1:0]      col_in,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [CW-1:0]        event_code,
  output logic                 event_press,
  output logic [ROWS*COLS-1:0] pressed_map
);

  localparam int unsigned NKEYS = ROWS * COLS;
  localparam int unsigned RW    = code_width(ROWS);
  localparam int unsigned SW    = $clog2(SETTLE_CYCLES + 2);
  localparam int unsigned DW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] STABLE_MAX  = DW'(DEBOUNCE_SCANS);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] KEY_LAST    = CW'(NKEYS - 1);
`ifdef KEYPAD_SCANNER_RELEASE_EVENTS_EN
  localparam logic REL_EVENTS = 1'b1;
`else
  localparam logic REL_EVENTS = 1'b0;
`endif

  scan_state_e      state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [DW-1:0]    stable_q, stable_d, stable_new;
  logic [CW-1:0]    key_q, key_d;
  logic [NKEYS-1:0] raw_q, raw_d, prev_q, prev_d, map_q, map_d;
  logic             valid_q, valid_d, press_q, press_d, key_adv;
  logic [CW-1:0]    code_q, code_d;
  logic [COLS-1:0]  col_sync, col_act;

  sync_2ff #(
    .WIDTH    (COLS),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(IDLE_LEVEL)
  ) u_col_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (col_in),
    .q_o  (col_sync)
  );

  assign col_act = IDLE_LEVEL ? ~col_sync : col_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_DRIVE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      settle_q <= '0;
      stable_q <= '0;
      key_q    <= '0;
      raw_q    <= '0;
      prev_q   <= '0;
      map_q    <= '0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      press_q  <= 1'b0;
    end else begin
      row_q    <= row_d;
      settle_q <= settle_d;
      stable_q <= stable_d;
      key_q    <= key_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      map_q    <= map_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      press_q  <= press_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    settle_d   = settle_q;
    stable_d   = stable_q;
    stable_new = '0;
    key_d      = key_q;
    raw_d      = raw_q;
    prev_d     = prev_q;
    map_d      = map_q;
    valid_d    = valid_q;
    code_d     = code_q;
    press_d    = press_q;
    key_adv    = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        raw_d[32'(row_q)*COLS +: COLS] = col_act;
        if (row_q == ROW_LAST) begin
          state_d = ST_COMPARE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_COMPARE: begin
        if (raw_q != prev_q) begin
          prev_d     = raw_q;
          stable_new = '0;
        end else begin
          stable_new = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
        end
        stable_d = stable_new;
        if (stable_new == STABLE_MAX && raw_q != map_q) begin
          key_d   = '0;
          state_d = ST_EMIT;
        end else begin
          row_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_EMIT: begin
        // A presented event holds the walk at key_q until the consumer takes it.
        if (valid_q) begin
          if (event_ready) begin
            map_d[key_q] = raw_q[key_q];
            valid_d      = 1'b0;
            key_adv      = 1'b1;
          end
        end else if (raw_q[key_q] != map_q[key_q]) begin
          if (raw_q[key_q] || REL_EVENTS) begin
            valid_d = 1'b1;
            code_d  = key_q;
            press_d = raw_q[key_q];
          end else begin
            map_d[key_q] = 1'b0;
            key_adv      = 1'b1;
          end
        end else begin
          key_adv = 1'b1;
        end
        if (key_adv) begin
          if (key_q == KEY_LAST) begin
            row_d   = '0;
            state_d = ST_DRIVE;
          end else begin
            key_d = key_q + 1'b1;
          end
        end
      end
      default: state_d = ST_DRIVE;
    endcase
  end

  always_comb begin
    row_out = {ROWS{IDLE_LEVEL}};
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (RW'(r) == row_q) row_out[r] = ~IDLE_LEVEL;
    end
    event_valid = valid_q;
    event_code  = code_q;
    event_press = press_q;
    pressed_map = map_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic        event_valid;
  logic        event_ready;
  logic [3:0]  event_code;
  logic        event_press;
  logic [15:0] pressed_map;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int ev_code[$];
  int ev_press[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS          (4),
    .COLS          (4),
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(3),
    .IDLE_LEVEL    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_out    (row_out),
    .col_in     (col_in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_code (event_code),
    .event_press(event_press),
    .pressed_map(pressed_map)
  );

  // Pressed key shorts its column to the active (low) row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst && event_valid && event_ready) begin
      ev_code.push_back(int'(event_code));
      ev_press.push_back(int'(event_press));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int code_at(input int i);
    return (i < ev_code.size()) ? ev_code[i] : -1;
  endfunction

  function automatic int press_at(input int i);
    return (i < ev_press.size()) ? ev_press[i] : -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input int n, input int budget);
    int cnt = 0;
    while (ev_code.size() < n && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic wait_valid(input int budget);
    int cnt = 0;
    while (event_valid !== 1'b1 && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  logic stall_ok;

  initial begin
    keys        = '0;
    event_ready = 1'b1;
    #1;
    chk("reset_valid", 32'(event_valid), 0);
    chk("reset_map", 32'(pressed_map), 0);
    chk("reset_row", 32'(row_out), 32'b1110);
    chk("reset_code", 32'(event_code), 0);
    chk("reset_press", 32'(event_press), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single held key
    keys[6] = 1'b1;
    wait_ev(1, 300);
    chk("s1_count", ev_code.size(), 1);
    chk("s1_code", code_at(0), 6);
    chk("s1_press", press_at(0), 1);
    chk("s1_map", 32'(pressed_map), 32'h0040);
    cycles(150);
    chk("s1_norepeat", ev_code.size(), 1);

    // Release after debounced press
    ev_code.delete(); ev_press.delete();
    keys[6] = 1'b0;
    cycles(250);
`ifdef KEYPAD_SCANNER_RELEASE_EVENTS_EN
    chk("s2_count", ev_code.size(), 1);
    chk("s2_code", code_at(0), 6);
    chk("s2_press", press_at(0), 0);
`else
    chk("s2_count", ev_code.size(), 0);
`endif
    chk("s2_map", 32'(pressed_map), 0);

    // Bounce: toggle once per scan period (29 cycles)
    ev_code.delete(); ev_press.delete();
    for (int i = 0; i < 10; i++) begin
      keys[6] = ~keys[6];
      repeat (29) @(posedge clk);
      #1;
    end
    cycles(150);
    chk("s3_count", ev_code.size(), 0);
    chk("s3_map", 32'(pressed_map), 0);

    // Two simultaneous presses, ascending order
    ev_code.delete(); ev_press.delete();
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    wait_ev(2, 300);
    chk("s4_count", ev_code.size(), 2);
    chk("s4_code0", code_at(0), 0);
    chk("s4_press0", press_at(0), 1);
    chk("s4_code1", code_at(1), 15);
    chk("s4_press1", press_at(1), 1);
    chk("s4_map", 32'(pressed_map), 32'h8001);
    keys = '0;
    cycles(300);
`ifdef KEYPAD_SCANNER_RELEASE_EVENTS_EN
    chk("s4_rel_count", ev_code.size(), 4);
`else
    chk("s4_rel_count", ev_code.size(), 2);
`endif
    chk("s4_rel_map", 32'(pressed_map), 0);

    // Stalled consumer
    ev_code.delete(); ev_press.delete();
    event_ready = 1'b0;
    keys[5]  = 1'b1;
    keys[10] = 1'b1;
    wait_valid(300);
    chk("s5_valid", 32'(event_valid), 1);
    chk("s5_code", 32'(event_code), 5);
    chk("s5_press", 32'(event_press), 1);
    chk("s5_row", 32'(row_out), 32'b0111);
    stall_ok = 1'b1;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (event_valid !== 1'b1 || event_code !== 4'd5 || event_press !== 1'b1 ||
          row_out !== 4'b0111) stall_ok = 1'b0;
    end
    chk("s5_hold", 32'(stall_ok), 1);
    chk("s5_none", ev_code.size(), 0);
    event_ready = 1'b1;
    wait_ev(2, 100);
    chk("s5_count", ev_code.size(), 2);
    chk("s5_code0", code_at(0), 5);
    chk("s5_code1", code_at(1), 10);
    chk("s5_map", 32'(pressed_map), 32'h0420);

    // Reset while an event is presented
    ev_code.delete(); ev_press.delete();
    event_ready = 1'b0;
    keys[3] = 1'b1;
    wait_valid(300);
    chk("s6_valid", 32'(event_valid), 1);
    chk("s6_code", 32'(event_code), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", 32'(event_valid), 0);
    chk("s6_rst_map", 32'(pressed_map), 0);
    chk("s6_rst_row", 32'(row_out), 32'b1110);
    repeat (3) @(negedge clk);
    chk("s6_rst_row_hold", 32'(row_out), 32'b1110);
    rst = 1'b0;
    event_ready = 1'b1;
    #1;
    chk("s6_post_row", 32'(row_out), 32'b1110);
    wait_ev(3, 400);
    chk("s6_count", ev_code.size(), 3);
    chk("s6_code0", code_at(0), 3);
    chk("s6_code1", code_at(1), 5);
    chk("s6_code2", code_at(2), 10);
    chk("s6_map", 32'(pressed_map), 32'h0428);
    keys = '0;
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
